riscv_fetch_unit: RTL and testbench

//  Parametrised instruction fetch unit for the RISC-V core. It replaces the bare PC register and the
//  PC+4 / branch-target select used by the single-cycle datapath.
//  - Generates sequential fetch addresses and fetches over a variable-latency req/ack memory port.
//  - Buffers fetched words with their PCs in a DEPTH-entry prefetch FIFO.
//  - Hands words to decode over a valid/ready handshake.
//  - Flushes on a branch/jump redirect from execute.

---
 rtl/riscv_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: sequential fetch over a req/ack port, DEPTH-entry prefetch FIFO, redirect flush.
// Optional build macro FETCH_PERF_EN adds decode-transfer and flush performance counters.
module riscv_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_flush_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]     inst_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] fetch_pc_nxt_s;
  logic [XLEN-1:0] addr_r;
  logic [XLEN-1:0] addr_nxt_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            req_r;
  logic            req_nxt_s;
  logic            drop_r;
  logic            drop_nxt_s;
  logic            ack_s;
  logic            hold_s;
  logic            push_s;
  logic            pop_s;

  assign redirect_pc_s = redirect_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign ack_s         = req_r & imem_ack_i;
  assign hold_s        = req_r & ~imem_ack_i;
  assign push_s        = ack_s & ~drop_r & ~redirect_i;
  assign inst_valid_o  = (count_r != {CW{1'b0}}) & ~redirect_i;
  assign pop_s         = inst_valid_o & inst_ready_i;
  assign imem_req_o    = req_r;
  assign imem_addr_o   = addr_r;
  assign inst_o        = inst_mem_r[rd_ptr_r];
  assign inst_pc_o     = pc_mem_r[rd_ptr_r];

  // Next-state for occupancy, fetch PC, drop flag and the request/address pair.
  always_comb begin
    count_nxt_s    = count_r;
    fetch_pc_nxt_s = fetch_pc_r;
    drop_nxt_s     = drop_r;
    req_nxt_s      = req_r;
    addr_nxt_s     = addr_r;
    if (redirect_i) begin
      count_nxt_s    = {CW{1'b0}};
      fetch_pc_nxt_s = redirect_pc_s;
    end else begin
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CW'(1);
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CW'(1);
      end else begin
        count_nxt_s = count_r;
      end
      if (push_s) begin
        fetch_pc_nxt_s = fetch_pc_r + XLEN'(4);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
    end
    // A redirect that lands on an unacked request must let that request complete and discard it.
    if (ack_s) begin
      drop_nxt_s = 1'b0;
    end else if (redirect_i && hold_s) begin
      drop_nxt_s = 1'b1;
    end else begin
      drop_nxt_s = drop_r;
    end
    if (hold_s) begin
      req_nxt_s  = 1'b1;
      addr_nxt_s = addr_r;
    end else begin
      req_nxt_s  = (count_nxt_s < CW'(DEPTH));
      addr_nxt_s = fetch_pc_nxt_s;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r      <= 1'b0;
      addr_r     <= RESET_PC;
      fetch_pc_r <= RESET_PC;
      drop_r     <= 1'b0;
    end else begin
      req_r      <= req_nxt_s;
      addr_r     <= addr_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      drop_r     <= drop_nxt_s;
    end
  end

  // Prefetch FIFO pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]   <= {XLEN{1'b0}};
      end
    end else begin
      count_r <= count_nxt_s;
      if (redirect_i) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          inst_mem_r[wr_ptr_r] <= imem_rdata_i;
          pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
          wr_ptr_r             <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running transfer and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_o <= 32'h0000_0000;
      perf_flush_cnt_o <= 32'h0000_0000;
    end else begin
      if (pop_s) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end
      if (redirect_i) begin
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: directed scenarios push expected fetch addresses and
// decode PCs; a negedge monitor pops and compares on every ack and every decode transfer.
`timescale 1ns/1ps
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  int          ack_budget = 0;
  int          acks_done  = 0;
  int          wait_cnt   = 0;
  int          lat        = 0;
  int          n_checks   = 0;
  int          n_pass     = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  riscv_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory model: acks after `lat` wait cycles while the granted ack budget lasts.
  assign imem_ack_i   = imem_req_o && (acks_done < ack_budget) && (wait_cnt >= lat);
  assign imem_rdata_i = word_of(imem_addr_o);

  always @(posedge clk) begin
    if (imem_req_o && imem_ack_i) begin
      acks_done <= acks_done + 1;
      wait_cnt  <= 0;
    end else if (imem_req_o) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // Monitor: every ack checks the fetch address, every decode transfer checks PC and word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_o && imem_ack_i) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_fetch: addr 0x%08h acked, none expected", imem_addr_o);
        end else begin
          chk("fetch_addr", imem_addr_o, exp_addr_q[0]);
          void'(exp_addr_q.pop_front());
        end
      end
      if (inst_valid_o && inst_ready_i) begin
        if (exp_pc_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_inst: pc 0x%08h transferred, none expected", inst_pc_o);
        end else begin
          chk("inst_pc", inst_pc_o, exp_pc_q[0]);
          chk("inst_word", inst_o, word_of(exp_pc_q[0]));
          void'(exp_pc_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_addr(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_both(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_pc_q.push_back(a);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0000_0000;
    lat           = 0;
    #1;
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h0);
    exp_addr_q.delete();
    exp_pc_q.delete();
    ack_budget = acks_done;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic end_test(input string name);
    chk({name, "_addr_q_drained"}, 32'(exp_addr_q.size()), 32'h0);
    chk({name, "_pc_q_drained"}, 32'(exp_pc_q.size()), 32'h0);
  endtask

  initial begin
    int  base;
    bit  found;
    rst_n         = 1'b0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0000_0000;

    // 1: zero-wait memory, ready=1, one instruction per cycle
    do_reset();
    inst_ready_i = 1'b1;
    ack_budget  += 6;
    for (int i = 0; i < 6; i++) exp_both(32'(i * 4));
    @(negedge clk); chk("t1_no_req_before_edge", 32'(imem_req_o), 32'h0);
    @(negedge clk); chk("t1_first_req", 32'(imem_req_o), 32'h1);
    chk("t1_valid_cycle1", 32'(inst_valid_o), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("t1_stream_valid", 32'(inst_valid_o), 32'h1);
    end
    @(negedge clk); chk("t1_stream_end", 32'(inst_valid_o), 32'h0);
    cyc(3);
    end_test("t1");

    // 2: ready=0 fills exactly DEPTH entries, then drains in order and resumes at 0x10
    do_reset();
    base        = acks_done;
    ack_budget += 8;
    for (int i = 0; i < 8; i++) exp_both(32'(i * 4));
    cyc(7);
    @(negedge clk);
    chk("t2_full_no_req", 32'(imem_req_o), 32'h0);
    chk("t2_push_count", 32'(acks_done - base), 32'd4);
    chk("t2_head_pc", inst_pc_o, 32'h0);
    @(posedge clk); #1;
    inst_ready_i = 1'b1;
    cyc(14);
    end_test("t2");

    // 3: three entries buffered, redirect to 0x103 while the 0xC request is acked
    do_reset();
    ack_budget += 3;
    exp_addr(32'h0); exp_addr(32'h4); exp_addr(32'h8);
    cyc(6);
    @(negedge clk);
    chk("t3_valid_before", 32'(inst_valid_o), 32'h1);
    chk("t3_head_before", inst_pc_o, 32'h0);
    chk("t3_pending_addr", imem_addr_o, 32'hC);
    @(posedge clk); #1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    inst_ready_i  = 1'b1;
    ack_budget   += 3;
    exp_addr(32'hC); exp_both(32'h100); exp_both(32'h104);
    @(negedge clk); chk("t3_valid_in_redirect", 32'(inst_valid_o), 32'h0);
    @(posedge clk); #1;
    redirect_i = 1'b0;
    @(negedge clk);
    chk("t3_new_req", 32'(imem_req_o), 32'h1);
    chk("t3_new_addr", imem_addr_o, 32'h100);
    cyc(6);
    end_test("t3");

    // 4: 3-cycle latency, redirect in the second cycle of the 0x8 request
    do_reset();
    lat           = 3;
    inst_ready_i  = 1'b1;
    ack_budget   += 5;
    exp_both(32'h0); exp_both(32'h4); exp_addr(32'h8); exp_both(32'h200); exp_both(32'h204);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (imem_req_o && imem_addr_o == 32'h8) found = 1'b1;
    end
    chk("t4_req8_seen", 32'(found), 32'h1);
    @(posedge clk); #1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    @(negedge clk); chk("t4_valid_in_redirect", 32'(inst_valid_o), 32'h0);
    @(posedge clk); #1;
    redirect_i = 1'b0;
    @(negedge clk);
    chk("t4_req_held", 32'(imem_req_o), 32'h1);
    chk("t4_addr_held", imem_addr_o, 32'h8);
    cyc(30);
    end_test("t4");

    // 5: redirect near the top of the address space wraps to 0
    do_reset();
    inst_ready_i = 1'b1;
    cyc(2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    ack_budget   += 4;
    exp_addr(32'h0); exp_both(32'hFFFF_FFFC); exp_both(32'h0); exp_both(32'h4);
    cyc(1);
    redirect_i = 1'b0;
    cyc(8);
    end_test("t5");

`ifdef FETCH_PERF_EN
    // 6: ten transfers and two redirect cycles, then asynchronous reset clears the counters
    do_reset();
    chk("t6_fetch_cnt_rst", perf_fetch_cnt_o, 32'd0);
    chk("t6_flush_cnt_rst", perf_flush_cnt_o, 32'd0);
    inst_ready_i = 1'b1;
    ack_budget  += 10;
    for (int i = 0; i < 10; i++) exp_both(32'(i * 4));
    cyc(15);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    cyc(2);
    redirect_i = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("t6_fetch_cnt", perf_fetch_cnt_o, 32'd10);
    chk("t6_flush_cnt", perf_flush_cnt_o, 32'd2);
    end_test("t6");
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_fetch_cnt_async_clr", perf_fetch_cnt_o, 32'd0);
    chk("t6_flush_cnt_async_clr", perf_flush_cnt_o, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
